l1_dcache_req_fsm: RTL
======================

L1_DCACHE_REQ_FSM -- requirements
Module: l1_dcache_req_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT_RESP cycles before abort (timeout build only).
REQ-002 SHALL have ports clk in 1 clock; rst in 1 reset; reset rst, synchronous, active-low; clock clk.
REQ-003 SHALL have ports is_load_i in 1, is_store_i in 1, pipeline request strobes.
REQ-004 SHALL have ports op_size_i in 2 (00 B, 01 H, 10 W, 11 D), signed_i in 1, vaddr_lo_i in 3, sampled with the strobe.
REQ-005 SHALL have ports dtlb_hit_i in 1, dtlb_xcpt_i in 1, translation result.
REQ-006 SHALL have ports mem_req_ready_i in 1, mem_resp_valid_i in 1, mem_resp_nack_i in 1, mem_resp_data_i in 64, dcache handshake.
REQ-007 SHALL have port kill_i in 1, pipeline flush.
REQ-008 SHALL have outputs trns_ena_o 1, translation_req_o 1, mem_req_valid_o 1, str_rdy_o 1 (driving the adapter), busy_o 1, done_o 1, xcpt_o 1, timeout_o 1, ld_data_o 64.

Function
REQ-009 SHALL implement states IDLE, TRANS, REQ, WAIT_RESP, DONE, XCPT.
REQ-010 IDLE: on is_load_i|is_store_i SHALL latch op, size, signed, vaddr_lo and go TRANS next cycle; both strobes high -> store wins.
REQ-011 TRANS: trns_ena_o=1, translation_req_o=1; dtlb_xcpt_i -> XCPT (xcpt priority over hit); dtlb_hit_i -> REQ; else stay.
REQ-012 REQ: mem_req_valid_o=1 held until mem_req_ready_i; on accept store -> DONE, load -> WAIT_RESP.
REQ-013 str_rdy_o SHALL be 1 in REQ and WAIT_RESP only (freezes adapter physical address captured at TRANS->REQ edge).
REQ-014 WAIT_RESP: mem_resp_nack_i -> REQ (replay, unbounded); mem_resp_valid_i -> DONE, registering formatted data; nack wins if both.
REQ-015 DONE: done_o=1 for exactly one cycle, then IDLE; ld_data_o holds until next load response.
REQ-016 XCPT: xcpt_o=1 for exactly one cycle, then IDLE; no mem request issued.
REQ-017 busy_o SHALL be 1 in every state except IDLE; new strobes outside IDLE ignored.
REQ-018 Load format: raw = mem_resp_data_i >> (8*vaddr_lo); keep low 8/16/32/64 bits per size; sign-extend if signed_i else zero-extend; W at vaddr_lo>4, H at 7 SHALL yield zero data (misaligned, upstream trapped).
REQ-019 Load latency: response at cycle N -> ld_data_o valid and done_o=1 at N+1.
REQ-020 kill_i in TRANS or REQ SHALL return to IDLE next cycle, no done_o/xcpt_o; in WAIT_RESP SHALL set killed flag, wait for valid/nack, then IDLE silently; ignored in IDLE/DONE/XCPT.

Reset
REQ-021 On rst=0 at clk edge: state IDLE, killed flag 0, timeout counter 0, all outputs 0, ld_data_o 64'h0.
REQ-022 Reset mid-transaction SHALL abandon it; no pulse output after reset release.

Configuration
REQ-023 With L1_DCACHE_REQ_TIMEOUT_EN defined: 8-bit counter cleared on WAIT_RESP entry, increments per WAIT_RESP cycle; at TIMEOUT_CYCLES without response -> timeout_o 1-cycle pulse and IDLE; late response in IDLE dropped.
REQ-024 Without L1_DCACHE_REQ_TIMEOUT_EN: no counter, timeout_o tied 0, WAIT_RESP waits indefinitely.

Structure
REQ-025 Shared package l1_dcache_pkg SHALL hold state encoding, size encodings (SZ_B..SZ_D) and default timeout constant.
REQ-026 Load formatting SHALL be combinational sub-module l1_dcache_load_align (data, size, signed, vaddr_lo -> 64-bit result).

Verification
REQ-027 Store: is_store_i, hit after 2 cycles, ready immediate -> mem_req_valid_o 1 cycle, done_o 1 cycle later, no WAIT_RESP.
REQ-028 Signed byte load: vaddr_lo=3, resp data 64'h0000_0000_8000_0000 -> ld_data_o 64'hFFFF_FFFF_FFFF_FF80; unsigned -> 64'h80.
REQ-029 dtlb_xcpt_i and dtlb_hit_i together in TRANS -> xcpt_o pulse, mem_req_valid_o never 1.
REQ-030 Load, nack twice then valid -> three REQ entries, one done_o; kill_i in WAIT_RESP -> no done_o, IDLE after response.
REQ-031 Timeout build, TIMEOUT_CYCLES=4, no response -> timeout_o after 4 WAIT_RESP cycles; rst=0 during REQ -> all outputs 0 next cycle.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// Shared definitions for the L1 data-cache request sequencer:
// state encoding, access-size encodings and the default response timeout.
package l1_dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRANS,
        ST_REQ,
        ST_WAIT_RESP,
        ST_DONE,
        ST_XCPT
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int L1_DEF_TIMEOUT = 255;
    localparam int TO_CNT_W       = 8;

endpackage

// File: rtl/l1_dcache_load_align.sv
// Combinational load formatter: shifts the 64-bit response down to the accessed
// byte lane, truncates to the access size and sign- or zero-extends.
module l1_dcache_load_align
    import l1_dcache_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [2:0]  i_vaddrLo,
    output logic [63:0] o_result
);

    logic [63:0] w_raw;

    assign w_raw = i_data >> {i_vaddrLo, 3'b000};

    // Accesses that would straddle the doubleword were already trapped upstream, so they return zero.
    always_comb begin
        o_result = '0;
        case (i_size)
            SZ_B: o_result = {{56{i_signed & w_raw[7]}}, w_raw[7:0]};
            SZ_H: if (i_vaddrLo != 3'd7) o_result = {{48{i_signed & w_raw[15]}}, w_raw[15:0]};
            SZ_W: if (i_vaddrLo <= 3'd4) o_result = {{32{i_signed & w_raw[31]}}, w_raw[31:0]};
            SZ_D: o_result = w_raw;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/l1_dcache_req_fsm.sv
// L1 data-cache request sequencer: translate, issue to dcache, await/replay response.
// Define L1_DCACHE_REQ_TIMEOUT_EN to abort WAIT_RESP after TIMEOUT_CYCLES cycles.
module l1_dcache_req_fsm
    import l1_dcache_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = L1_DEF_TIMEOUT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  op_size_i,
    input  logic        signed_i,
    input  logic [2:0]  vaddr_lo_i,
    input  logic        dtlb_hit_i,
    input  logic        dtlb_xcpt_i,
    input  logic        mem_req_ready_i,
    input  logic        mem_resp_valid_i,
    input  logic        mem_resp_nack_i,
    input  logic [63:0] mem_resp_data_i,
    input  logic        kill_i,
    output logic        trns_ena_o,
    output logic        translation_req_o,
    output logic        mem_req_valid_o,
    output logic        str_rdy_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        xcpt_o,
    output logic        timeout_o,
    output logic [63:0] ld_data_o
);

`ifdef L1_DCACHE_REQ_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] r_toCnt;
    logic                r_timeout;
    logic                w_toFire;
`endif

    state_t      r_state;
    state_t      w_nextState;
    logic        r_isStore;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [2:0]  r_vaddrLo;
    logic        r_killed;
    logic [63:0] r_ldData;
    logic [63:0] w_alignData;
    logic        w_killed;

    assign w_killed = r_killed | kill_i;

    l1_dcache_load_align u_align (
        .i_data    (mem_resp_data_i),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .i_vaddrLo (r_vaddrLo),
        .o_result  (w_alignData)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
`ifdef L1_DCACHE_REQ_TIMEOUT_EN
        w_toFire = 1'b0;
`endif
        case (r_state)
            ST_IDLE:  if (is_load_i | is_store_i) w_nextState = ST_TRANS;
            ST_TRANS: begin
                if (kill_i)           w_nextState = ST_IDLE;
                else if (dtlb_xcpt_i) w_nextState = ST_XCPT;
                else if (dtlb_hit_i)  w_nextState = ST_REQ;
            end
            ST_REQ: begin
                if (kill_i)               w_nextState = ST_IDLE;
                else if (mem_req_ready_i) w_nextState = r_isStore ? ST_DONE : ST_WAIT_RESP;
            end
            // A killed request still owns the dcache until it answers, then leaves silently.
            ST_WAIT_RESP: begin
                if (mem_resp_nack_i)       w_nextState = w_killed ? ST_IDLE : ST_REQ;
                else if (mem_resp_valid_i) w_nextState = w_killed ? ST_IDLE : ST_DONE;
`ifdef L1_DCACHE_REQ_TIMEOUT_EN
                else if (r_toCnt == TO_LAST) begin
                    w_nextState = ST_IDLE;
                    w_toFire    = ~w_killed;
                end
`endif
            end
            ST_DONE, ST_XCPT: w_nextState = ST_IDLE;
            default:          w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        trns_ena_o        = 1'b0;
        translation_req_o = 1'b0;
        mem_req_valid_o   = 1'b0;
        str_rdy_o         = 1'b0;
        done_o            = 1'b0;
        xcpt_o            = 1'b0;
        busy_o            = (r_state != ST_IDLE);
        case (r_state)
            ST_TRANS: begin
                trns_ena_o        = 1'b1;
                translation_req_o = 1'b1;
            end
            ST_REQ: begin
                mem_req_valid_o = 1'b1;
                str_rdy_o       = 1'b1;
            end
            ST_WAIT_RESP: str_rdy_o = 1'b1;
            ST_DONE:      done_o    = 1'b1;
            ST_XCPT:      xcpt_o    = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_isStore <= 1'b0;
            r_size    <= SZ_B;
            r_signed  <= 1'b0;
            r_vaddrLo <= 3'd0;
            r_killed  <= 1'b0;
            r_ldData  <= 64'h0;
        end else begin
            if (r_state == ST_IDLE && (is_load_i | is_store_i)) begin
                r_isStore <= is_store_i;
                r_size    <= op_size_i;
                r_signed  <= signed_i;
                r_vaddrLo <= vaddr_lo_i;
            end
            if (r_state == ST_WAIT_RESP && mem_resp_valid_i && !mem_resp_nack_i && !w_killed)
                r_ldData <= w_alignData;
            r_killed <= (r_state == ST_WAIT_RESP && w_nextState == ST_WAIT_RESP) ? w_killed : 1'b0;
        end
    end

`ifdef L1_DCACHE_REQ_TIMEOUT_EN
    // Counter sits at zero outside WAIT_RESP, so every entry starts a fresh window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_toCnt   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_toCnt   <= (r_state == ST_WAIT_RESP) ? r_toCnt + 1'b1 : '0;
            r_timeout <= w_toFire;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign ld_data_o = r_ldData;

endmodule
